// File: rtl/preaddmult_pipe.sv
// Four-stage signed pre-adder/multiplier ((a op b) * c) with a valid flag carried alongside the data.
// Define PREADDMULT_ACC_EN to turn the output stage into a wrapping accumulator.
module preaddmult_pipe #(
    parameter int AW   = 16,
    parameter int BW   = 16,
    parameter int CW   = 16,
    parameter int OUTW = 48
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            in_valid,
    input  logic [1:0]      mode,
    input  logic [AW-1:0]   a,
    input  logic [BW-1:0]   b,
    input  logic [CW-1:0]   c,
    input  logic            acc_clr,
    output logic            out_valid,
    output logic [OUTW-1:0] dout
);

    localparam int PAW = ((AW > BW) ? AW : BW) + 1;
    localparam int MW  = PAW + CW;

    logic signed [AW-1:0]   a_s1;
    logic signed [BW-1:0]   b_s1;
    logic signed [CW-1:0]   c_s1;
    logic [1:0]             mode_s1;
    logic                   valid_s1;

    logic signed [PAW-1:0]  a_ext;
    logic signed [PAW-1:0]  b_ext;
    logic signed [PAW-1:0]  preadd;

    logic signed [PAW-1:0]  preadd_s2;
    logic signed [CW-1:0]   c_s2;
    logic                   valid_s2;

    logic signed [MW-1:0]   prod;
    logic signed [MW-1:0]   m_s3;
    logic                   valid_s3;

    logic signed [OUTW-1:0] m_ext;
    logic signed [OUTW-1:0] p;

`ifdef PREADDMULT_ACC_EN
    logic clr_s1;
    logic clr_s2;
    logic clr_s3;
`else
    logic unused_acc_clr;
    assign unused_acc_clr = acc_clr;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_s1     <= '0;
            b_s1     <= '0;
            c_s1     <= '0;
            mode_s1  <= '0;
            valid_s1 <= 1'b0;
        end else if (ce) begin
            a_s1     <= a;
            b_s1     <= b;
            c_s1     <= c;
            mode_s1  <= mode;
            valid_s1 <= in_valid;
        end
    end

    // One guard bit on top of the wider operand makes every mode overflow-free.
    assign a_ext = PAW'(a_s1);
    assign b_ext = PAW'(b_s1);

    always_comb begin
        preadd = a_ext;
        case (mode_s1)
            2'b00:   preadd = a_ext + b_ext;
            2'b01:   preadd = a_ext - b_ext;
            2'b10:   preadd = b_ext - a_ext;
            default: preadd = a_ext;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            preadd_s2 <= '0;
            c_s2      <= '0;
            valid_s2  <= 1'b0;
        end else if (ce) begin
            preadd_s2 <= preadd;
            c_s2      <= c_s1;
            valid_s2  <= valid_s1;
        end
    end

    assign prod = MW'(preadd_s2) * MW'(c_s2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_s3     <= '0;
            valid_s3 <= 1'b0;
        end else if (ce) begin
            m_s3     <= prod;
            valid_s3 <= valid_s2;
        end
    end

    assign m_ext = OUTW'(m_s3);

`ifdef PREADDMULT_ACC_EN
    // The clear flag only matters for real samples, so it is qualified on entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
            clr_s3 <= 1'b0;
        end else if (ce) begin
            clr_s1 <= in_valid & acc_clr;
            clr_s2 <= clr_s1;
            clr_s3 <= clr_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (valid_s3) begin
                p <= (clr_s3 ? '0 : p) + m_ext;
            end
            out_valid <= valid_s3;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p         <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            p         <= m_ext;
            out_valid <= valid_s3;
        end
    end
`endif

    assign dout = p;

endmodule

// File: tb/tb_preaddmult_pipe.sv
// Scoreboard bench for preaddmult_pipe: a reference model queues expected results with their due
// cycle, and a negedge monitor pops them against out_valid/dout, also checking stall and reset behaviour.
module tb_preaddmult_pipe;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int CW = 16;
`ifdef PREADDMULT_ACC_EN
    localparam int OUTW = 33;
`else
    localparam int OUTW = 48;
`endif

    typedef struct {
        logic [OUTW-1:0] val;
        int              due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ce;
    logic            in_valid;
    logic [1:0]      mode;
    logic [AW-1:0]   a;
    logic [BW-1:0]   b;
    logic [CW-1:0]   c;
    logic            acc_clr;
    logic            out_valid;
    logic [OUTW-1:0] dout;

    exp_t            sb[$];
    exp_t            popped;
    int              checks = 0;
    int              errors = 0;
    int              edgeCount = 0;
    bit              lastEn = 1'b0;
    bit              lastRst = 1'b0;
    bit              monitorOn = 1'b0;
    logic [OUTW-1:0] accModel = '0;
    logic [OUTW-1:0] prevDout;
    logic            prevValid;

    preaddmult_pipe #(.AW(AW), .BW(BW), .CW(CW), .OUTW(OUTW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .c(c), .acc_clr(acc_clr), .out_valid(out_valid), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle; valid enabled samples get their expected result and due cycle queued.
    task automatic applyStimulus(input logic v, input logic [1:0] m, input int av, input int bv,
                                 input int cv, input logic clr, input logic en);
        longint pre;
        longint prd;
        exp_t   item;
        in_valid = v;
        mode     = m;
        a        = AW'(av);
        b        = BW'(bv);
        c        = CW'(cv);
        acc_clr  = clr;
        ce       = en;
        if (v && en) begin
            case (m)
                2'b00:   pre = longint'(av) + longint'(bv);
                2'b01:   pre = longint'(av) - longint'(bv);
                2'b10:   pre = longint'(bv) - longint'(av);
                default: pre = longint'(av);
            endcase
            prd = pre * longint'(cv);
`ifdef PREADDMULT_ACC_EN
            accModel = (clr ? '0 : accModel) + OUTW'(prd);
            item.val = accModel;
`else
            item.val = OUTW'(prd);
`endif
            item.due = edgeCount + 4;
            sb.push_back(item);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 2'b00, 0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
        idle(2);
    endtask

    always @(posedge clk) begin
        lastEn  = rst_n && ce;
        lastRst = !rst_n;
        if (lastEn) edgeCount++;
    end

    always @(negedge clk) begin
        if (monitorOn) begin
            if (lastRst) begin
                checkOutput("rst_valid", 64'(out_valid), 64'd0);
                checkOutput("rst_dout", 64'(dout), 64'd0);
            end else if (!lastEn) begin
                checkOutput("stall_valid", 64'(out_valid), 64'(prevValid));
                checkOutput("stall_dout", 64'(dout), 64'(prevDout));
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    popped = sb.pop_front();
                    checkOutput("dout", 64'(dout), 64'(popped.val));
                    checkOutput("latency", 64'(edgeCount), 64'(popped.due));
                end
            end
`ifdef PREADDMULT_ACC_EN
            else begin
                checkOutput("bubble_hold", 64'(dout), 64'(prevDout));
            end
`endif
            prevDout  = dout;
            prevValid = out_valid;
        end
    end

    initial begin
        int ta[5] = '{100, -200, 300, -400, 1234};
        int tb[5] = '{7, -8, 9000, 10, -55};
        int tc[5] = '{-3, 4, -5, 6, 77};
        rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; mode = 2'b00;
        a = '0; b = '0; c = '0; acc_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_dout", 64'(dout), 64'd0);
        rst_n     = 1'b1;
        prevDout  = dout;
        prevValid = out_valid;
        monitorOn = 1'b1;

        // Single sample: (3+5)*7
        applyStimulus(1'b1, 2'b00, 3, 5, 7, 1'b1, 1'b1);
        idle(6);
        drain(10);

        // Extreme operands in subtract, reverse subtract and bypass modes
        applyStimulus(1'b1, 2'b01, -32768, 32767, -32768, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b10, -32768, 32767, -32768, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b11, -32768, 999, 2, 1'b1, 1'b1);
        drain(10);

        // Back-to-back stream with a three-cycle ce stall holding a valid input that must not be taken
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                repeat (3) applyStimulus(1'b1, 2'b01, 99, 98, 97, 1'b1, 1'b0);
            end
            applyStimulus(1'b1, 2'(i), ta[i], tb[i], tc[i], 1'b1, 1'b1);
        end
        drain(12);

        // Reset with three samples in flight, ce low during reset
        applyStimulus(1'b1, 2'b00, 11, 12, 13, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b01, 21, 22, 23, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b10, 31, 32, 33, 1'b1, 1'b1);
        rst_n    = 1'b0;
        ce       = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        accModel = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        applyStimulus(1'b1, 2'b00, -9, 4, 6, 1'b1, 1'b1);
        drain(10);

`ifdef PREADDMULT_ACC_EN
        // Accumulation: 4, 10, 14, bubble, then restart with 7
        applyStimulus(1'b1, 2'b00, 1, 1, 2, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b00, 2, 0, 3, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b01, 5, 1, 1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 50, 50, 50, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b00, 7, 0, 1, 1'b1, 1'b1);
        drain(12);

        // Repeated largest positive product (2^31) wraps modulo 2^33
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'b00, -32768, -32768, -32768, (i == 0), 1'b1);
        end
        drain(12);
`endif

        checkOutput("final_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
